// File: rtl/id_ex_ctrl_stage.sv
// ID/EX control pipeline register with load-use hazard detection, EX-resolved flush
// and saturating stall/flush performance counters.
module id_ex_ctrl_stage #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [1:0]            id_alu_op,
  input  logic                  id_reg_dst,
  input  logic                  id_branch,
  input  logic                  id_mem_read,
  input  logic                  id_mem_2_reg,
  input  logic                  id_mem_write,
  input  logic                  id_alu_src,
  input  logic                  id_reg_write,
  input  logic                  id_jump,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ex_flush,
  output logic                  ex_valid,
  output logic [1:0]            ex_alu_op,
  output logic                  ex_reg_dst,
  output logic                  ex_branch,
  output logic                  ex_mem_read,
  output logic                  ex_mem_2_reg,
  output logic                  ex_mem_write,
  output logic                  ex_alu_src,
  output logic                  ex_reg_write,
  output logic                  ex_jump,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic load_use;
  logic rd_match;
  logic insert_bubble;

  // x0 is hard-wired zero, so a load into it can never feed a dependent instruction.
  assign rd_match = (ex_rd == id_rs1) || (ex_rd == id_rs2);
  assign load_use = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid && rd_match;

  // A flush squashes the waiting instruction, so there is nothing left to stall for.
  assign stall         = load_use && !ex_flush;
  assign insert_bubble = ex_flush || load_use;

  always_ff @(posedge clk) begin
    if (rst || insert_bubble) begin
      ex_valid     <= 1'b0;
      ex_alu_op    <= 2'b00;
      ex_reg_dst   <= 1'b0;
      ex_branch    <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_2_reg <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_alu_src   <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_jump      <= 1'b0;
      ex_rd        <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
    end else begin
      // Controls pass through even when id_valid=0; consumers qualify with ex_valid.
      ex_valid     <= id_valid;
      ex_alu_op    <= id_alu_op;
      ex_reg_dst   <= id_reg_dst;
      ex_branch    <= id_branch;
      ex_mem_read  <= id_mem_read;
      ex_mem_2_reg <= id_mem_2_reg;
      ex_mem_write <= id_mem_write;
      ex_alu_src   <= id_alu_src;
      ex_reg_write <= id_reg_write;
      ex_jump      <= id_jump;
      ex_rd        <= id_rd;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (ex_flush && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Scoreboard bench for id_ex_ctrl_stage: a reference model predicts the EX register,
// stall and both counters; EX predictions are queued at drive time and popped after each edge.
module tb_id_ex_ctrl_stage;

  localparam int RW = 5;
  localparam int CW = 2;
  localparam int VW = 26;

  // Vector layout shared by ID stimulus and EX observation:
  // {valid, alu_op[1:0], reg_dst, branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write, jump, rd, rs1, rs2}
  logic clk;
  logic rst;
  logic ex_flush;
  logic [VW-1:0] id_vec;
  logic [VW-1:0] ex_vec;

  logic          ex_valid, ex_reg_dst, ex_branch, ex_mem_read, ex_mem_2_reg;
  logic          ex_mem_write, ex_alu_src, ex_reg_write, ex_jump, stall;
  logic [1:0]    ex_alu_op;
  logic [RW-1:0] ex_rd, ex_rs1, ex_rs2;
  logic [CW-1:0] stall_cnt, flush_cnt;

  id_ex_ctrl_stage #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_vec[25]), .id_alu_op(id_vec[24:23]), .id_reg_dst(id_vec[22]),
    .id_branch(id_vec[21]), .id_mem_read(id_vec[20]), .id_mem_2_reg(id_vec[19]),
    .id_mem_write(id_vec[18]), .id_alu_src(id_vec[17]), .id_reg_write(id_vec[16]),
    .id_jump(id_vec[15]), .id_rd(id_vec[14:10]), .id_rs1(id_vec[9:5]), .id_rs2(id_vec[4:0]),
    .ex_flush(ex_flush),
    .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_reg_dst(ex_reg_dst),
    .ex_branch(ex_branch), .ex_mem_read(ex_mem_read), .ex_mem_2_reg(ex_mem_2_reg),
    .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
    .ex_jump(ex_jump), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .stall(stall), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign ex_vec = {ex_valid, ex_alu_op, ex_reg_dst, ex_branch, ex_mem_read, ex_mem_2_reg,
                   ex_mem_write, ex_alu_src, ex_reg_write, ex_jump, ex_rd, ex_rs1, ex_rs2};

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] m_ex;
  logic [CW-1:0] m_scnt, m_fcnt;
  bit            m_known;
  int            n_checks;
  int            n_errors;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] mk(input logic v, input logic [1:0] op, input logic [7:0] ctl,
                                       input logic [RW-1:0] rd, input logic [RW-1:0] rs1,
                                       input logic [RW-1:0] rs2);
    return {v, op, ctl, rd, rs1, rs2};
  endfunction

  // ctl byte order: reg_dst, branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write, jump
  localparam logic [7:0] CTL_LW = 8'b0011_0110;
  localparam logic [7:0] CTL_R  = 8'b1000_0010;

  // Driver: apply one ID/flush/rst cycle, predict, then compare after the edge.
  task automatic drive_cycle(input logic [VW-1:0] id, input logic flush, input logic r);
    logic lu, exp_stall;
    logic [VW-1:0] nxt;
    id_vec   = id;
    ex_flush = flush;
    rst      = r;
    lu = m_ex[25] && m_ex[20] && (m_ex[14:10] != '0) && id[25] &&
         ((m_ex[14:10] == id[9:5]) || (m_ex[14:10] == id[4:0]));
    exp_stall = lu && !flush;
    #1;
    if (m_known) check_val("stall", 32'(stall), 32'(exp_stall));
    if (r || flush || lu) nxt = '0;
    else                  nxt = id;
    if (r) begin
      m_scnt = '0;
      m_fcnt = '0;
    end else if (m_known) begin
      if (exp_stall && m_scnt != '1) m_scnt = m_scnt + 1'b1;
      if (flush && m_fcnt != '1)     m_fcnt = m_fcnt + 1'b1;
    end
    if (r) m_known = 1'b1;
    m_ex = nxt;
    if (m_known) exp_q.push_back(nxt);
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      check_val("ex_regs", 32'(ex_vec), 32'(exp_q.pop_front()));
      check_val("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
      check_val("flush_cnt", 32'(flush_cnt), 32'(m_fcnt));
    end
    @(negedge clk);
  endtask

  function automatic logic [VW-1:0] rand_id();
    return {1'(($urandom_range(0, 3) != 0)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_known  = 1'b0;
    m_ex     = '0;
    m_scnt   = '0;
    m_fcnt   = '0;
    rst      = 1'b1;
    ex_flush = 1'b0;
    id_vec   = '0;
    @(negedge clk);

    // Reset with random ID inputs
    drive_cycle(rand_id(), 1'b0, 1'b1);
    drive_cycle(rand_id(), 1'b0, 1'b1);
    check_val("rst_ex_zero", 32'(ex_vec), 32'(0));
    check_val("rst_stall", 32'(stall), 32'(0));

    // lw x5 then dependent add (held in ID during the stall)
    drive_cycle(mk(1, 2'b00, CTL_LW, 5'd5, 5'd1, 5'd0), 1'b0, 1'b0);
    drive_cycle(mk(1, 2'b10, CTL_R, 5'd6, 5'd5, 5'd2), 1'b0, 1'b0);
    check_val("lu_bubble_valid", 32'(ex_valid), 32'(0));
    drive_cycle(mk(1, 2'b10, CTL_R, 5'd6, 5'd5, 5'd2), 1'b0, 1'b0);
    check_val("lu_add_in_ex", 32'(ex_vec), 32'(mk(1, 2'b10, CTL_R, 5'd6, 5'd5, 5'd2)));
    check_val("lu_stall_cnt", 32'(stall_cnt), 32'(1));

    // lw x0 then user of x0: no stall
    drive_cycle(mk(1, 2'b00, CTL_LW, 5'd0, 5'd1, 5'd0), 1'b0, 1'b0);
    drive_cycle(mk(1, 2'b10, CTL_R, 5'd7, 5'd3, 5'd0), 1'b0, 1'b0);
    check_val("x0_no_stall_cnt", 32'(stall_cnt), 32'(1));

    // Load-use with simultaneous flush
    drive_cycle(rand_id(), 1'b0, 1'b1);
    drive_cycle(mk(1, 2'b00, CTL_LW, 5'd9, 5'd1, 5'd0), 1'b0, 1'b0);
    drive_cycle(mk(1, 2'b10, CTL_R, 5'd4, 5'd2, 5'd9), 1'b1, 1'b0);
    check_val("flush_lu_ex", 32'(ex_vec), 32'(0));
    check_val("flush_lu_fcnt", 32'(flush_cnt), 32'(1));
    check_val("flush_lu_scnt", 32'(stall_cnt), 32'(0));

    // Back-to-back independent R-type
    for (int i = 0; i < 6; i++)
      drive_cycle(mk(1, 2'b10, CTL_R, 5'(10 + i), 5'(20 + i), 5'(25 + i)), 1'b0, 1'b0);

    // Flush held 5 cycles: counter saturates at 3, then reset mid-run clears it
    drive_cycle(rand_id(), 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drive_cycle(rand_id(), 1'b1, 1'b0);
    check_val("fcnt_sat", 32'(flush_cnt), 32'(3));
    drive_cycle(rand_id(), 1'b1, 1'b1);
    check_val("fcnt_rst", 32'(flush_cnt), 32'(0));

    // Random traffic with a narrow register range to provoke hazards
    for (int i = 0; i < 300; i++)
      drive_cycle(rand_id(), 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 49) == 0));

    check_val("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
